// File: rtl/pipeline_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default geometry, issue latency
// per opcode class, and the counter-width helper used for port sizing.
package pipeline_scoreboard_pkg;

    localparam int REG_BITS_DEF = 5;
    localparam int MAX_LAT_DEF  = 8;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_LOAD,
        OP_FPADD,
        OP_FPMUL,
        OP_FPDIV
    } op_class_e;

    localparam int LAT_ALU   = 1;
    localparam int LAT_LOAD  = 2;
    localparam int LAT_FPADD = 3;
    localparam int LAT_FPMUL = 5;
    localparam int LAT_FPDIV = MAX_LAT_DEF;

    // Bits needed to hold every value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int class_latency(input op_class_e op);
        case (op)
            OP_ALU:   return LAT_ALU;
            OP_LOAD:  return LAT_LOAD;
            OP_FPADD: return LAT_FPADD;
            OP_FPMUL: return LAT_FPMUL;
            default:  return LAT_FPDIV;
        endcase
    endfunction

endpackage

// File: rtl/wb_reservation_line.sv
// MAX_LAT-deep shift line of writeback reservations (valid + rd); slot 0 is the
// writeback port, and a reservation of latency L lands in slot L-1 after the shift.
module wb_reservation_line
    import pipeline_scoreboard_pkg::*;
#(
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int REG_BITS = REG_BITS_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [cnt_width(MAX_LAT)-1:0] i_probe_lat,
    output logic                          o_probe_busy,
    input  logic                          i_wr_en,
    input  logic [cnt_width(MAX_LAT)-1:0] i_wr_lat,
    input  logic [REG_BITS-1:0]           i_wr_rd,
    output logic                          o_head_valid,
    output logic [REG_BITS-1:0]           o_head_rd
);

    logic                r_v  [MAX_LAT];
    logic [REG_BITS-1:0] r_rd [MAX_LAT];

    // Slot L-1 after the shift is today's slot L; nothing shifts into the top slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        o_probe_busy = 1'b0;
        for (int d = 1; d < MAX_LAT; d++) begin
            if (int'(i_probe_lat) == d) begin
                o_probe_busy = r_v[d];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: the line is an array but is still reset, so a mid-flight reset drops every reservation.
            for (int d = 0; d < MAX_LAT; d++) begin
                r_v[d]  <= 1'b0;
                r_rd[d] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout; the later write to the same slot wins the edge.
            for (int d = 0; d < MAX_LAT - 1; d++) begin
                r_v[d]  <= r_v[d+1];
                r_rd[d] <= r_rd[d+1];
            end
            r_v[MAX_LAT-1]  <= 1'b0;
            r_rd[MAX_LAT-1] <= '0;
            for (int d = 0; d < MAX_LAT; d++) begin
                if (i_wr_en && (int'(i_wr_lat) == d + 1)) begin
                    r_v[d]  <= 1'b1;
                    r_rd[d] <= i_wr_rd;
                end
            end
        end
    end

    assign o_head_valid = r_v[0];
    assign o_head_rd    = r_rd[0];

endmodule

// File: rtl/pipeline_scoreboard.sv
// Per-register countdown hazard scoreboard: stalls ID on RAW/WAW/writeback-port
// conflicts and announces the register retiring at writeback each cycle.
module pipeline_scoreboard
    import pipeline_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_BITS = REG_BITS_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_issue_valid,
    input  logic [REG_BITS-1:0]            i_issue_rs1,
    input  logic                           i_issue_use1,
    input  logic [REG_BITS-1:0]            i_issue_rs2,
    input  logic                           i_issue_use2,
    input  logic                           i_issue_wr,
    input  logic [REG_BITS-1:0]            i_issue_rd,
    input  logic [cnt_width(MAX_LAT)-1:0]  i_issue_lat,
    input  logic                           i_flush,
    output logic                           o_stall,
    output logic                           o_issue_fire,
    output logic                           o_wb_valid,
    output logic [REG_BITS-1:0]            o_wb_rd,
    output logic [cnt_width(NUM_REGS)-1:0] o_busy_count
);

    localparam int LAT_W  = cnt_width(MAX_LAT);
    localparam int BUSY_W = cnt_width(NUM_REGS);

    logic [LAT_W-1:0]  r_cnt      [NUM_REGS];
    logic [LAT_W-1:0]  w_cnt_next [NUM_REGS];
    logic [BUSY_W-1:0] r_busy_count;
    logic [BUSY_W-1:0] w_busy_next;

    logic [LAT_W-1:0]  w_lat;
    logic [LAT_W-1:0]  w_cnt_rs1;
    logic [LAT_W-1:0]  w_cnt_rs2;
    logic [LAT_W-1:0]  w_cnt_rd;
    logic              w_rd_ok;
    logic              w_rs1_zero;
    logic              w_rs2_zero;
    logic              w_rd_zero;
    logic              w_trk;
    logic              w_active;
    logic              w_raw;
    logic              w_waw;
    logic              w_struct;
    logic              w_slot_taken;
    logic              w_stall;
    logic              w_fire;
    logic              w_track_fire;

    always_comb begin
        w_lat = i_issue_lat;
        if (i_issue_lat == '0) begin
            w_lat = LAT_W'(1);
        end else if (int'(i_issue_lat) > MAX_LAT) begin
            w_lat = LAT_W'(MAX_LAT);
        end
    end

    assign w_rs1_zero = (ZERO_REG != 0) && (i_issue_rs1 == '0);
    assign w_rs2_zero = (ZERO_REG != 0) && (i_issue_rs2 == '0);
    assign w_rd_zero  = (ZERO_REG != 0) && (i_issue_rd == '0);

    always_comb begin
        w_cnt_rs1 = '0;
        w_cnt_rs2 = '0;
        w_cnt_rd  = '0;
        w_rd_ok   = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(i_issue_rs1) == r) w_cnt_rs1 = r_cnt[r];
            if (int'(i_issue_rs2) == r) w_cnt_rs2 = r_cnt[r];
            if (int'(i_issue_rd) == r) begin
                w_cnt_rd = r_cnt[r];
                w_rd_ok  = 1'b1;
            end
        end
    end

    assign w_trk    = i_issue_wr && w_rd_ok && !w_rd_zero;
    assign w_active = i_issue_valid && !i_flush && !i_reset;

    // A counter of 1 means the producer is on the writeback port this cycle and is forwarded.
    assign w_raw = (i_issue_use1 && !w_rs1_zero && (w_cnt_rs1 > LAT_W'(1)))
                || (i_issue_use2 && !w_rs2_zero && (w_cnt_rs2 > LAT_W'(1)));
    assign w_waw    = w_trk && (w_cnt_rd >= w_lat);
    assign w_struct = w_trk && w_slot_taken;

    assign w_stall      = w_active && (w_raw || w_waw || w_struct);
    assign w_fire       = w_active && !w_stall;
    assign w_track_fire = w_fire && w_trk;

    always_comb begin
        w_busy_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_cnt_next[r] = (r_cnt[r] != '0) ? (r_cnt[r] - LAT_W'(1)) : '0;
            if (w_track_fire && (int'(i_issue_rd) == r)) begin
                w_cnt_next[r] = w_lat;
            end
            if (w_cnt_next[r] != '0) begin
                w_busy_next = w_busy_next + BUSY_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_busy_count <= '0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_busy_count <= w_busy_next;
        end
    end

    wb_reservation_line #(
        .MAX_LAT  (MAX_LAT),
        .REG_BITS (REG_BITS)
    ) u_line (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_probe_lat  (w_lat),
        .o_probe_busy (w_slot_taken),
        .i_wr_en      (w_track_fire),
        .i_wr_lat     (w_lat),
        .i_wr_rd      (i_issue_rd),
        .o_head_valid (o_wb_valid),
        .o_head_rd    (o_wb_rd)
    );

    assign o_stall      = w_stall;
    assign o_issue_fire = w_fire;
    assign o_busy_count = r_busy_count;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench: directed hazard scenarios with literal expectations, then
// random issue traffic compared every cycle against a writeback-time model.
module tb_pipeline_scoreboard;
    import pipeline_scoreboard_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int REG_BITS = 5;
    localparam int MAX_LAT  = 8;
    localparam int LAT_W    = cnt_width(MAX_LAT);
    localparam int BUSY_W   = cnt_width(NUM_REGS);

    logic                clk = 1'b0;
    logic                reset;
    logic                issue_valid;
    logic [REG_BITS-1:0] issue_rs1;
    logic                issue_use1;
    logic [REG_BITS-1:0] issue_rs2;
    logic                issue_use2;
    logic                issue_wr;
    logic [REG_BITS-1:0] issue_rd;
    logic [LAT_W-1:0]    issue_lat;
    logic                flush;
    logic                stall;
    logic                issue_fire;
    logic                wb_valid;
    logic [REG_BITS-1:0] wb_rd;
    logic [BUSY_W-1:0]   busy_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_BITS (REG_BITS),
        .MAX_LAT  (MAX_LAT),
        .ZERO_REG (1)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_issue_valid (issue_valid),
        .i_issue_rs1   (issue_rs1),
        .i_issue_use1  (issue_use1),
        .i_issue_rs2   (issue_rs2),
        .i_issue_use2  (issue_use2),
        .i_issue_wr    (issue_wr),
        .i_issue_rd    (issue_rd),
        .i_issue_lat   (issue_lat),
        .i_flush       (flush),
        .o_stall       (stall),
        .o_issue_fire  (issue_fire),
        .o_wb_valid    (wb_valid),
        .o_wb_rd       (wb_rd),
        .o_busy_count  (busy_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: each in-flight result is just "register rd is written at cycle w".
    int t = 0;
    int last_wb [NUM_REGS];
    int slot_rd [int];

    function automatic int eff_lat(input int lat);
        if (lat < 1) return 1;
        if (lat > MAX_LAT) return MAX_LAT;
        return lat;
    endfunction

    initial begin
        for (int r = 0; r < NUM_REGS; r++) last_wb[r] = -10;
    end

    always @(negedge clk) begin : model
        int  l, rs1, rs2, rd, e_busy;
        bit  act, trk, e_stall, e_fire, e_wbv;
        l   = eff_lat(int'(issue_lat));
        rs1 = int'(issue_rs1);
        rs2 = int'(issue_rs2);
        rd  = int'(issue_rd);
        act = issue_valid && !flush && !reset;
        trk = issue_wr && (rd != 0);
        e_stall = act && ((issue_use1 && rs1 != 0 && last_wb[rs1] > t)
                       || (issue_use2 && rs2 != 0 && last_wb[rs2] > t)
                       || (trk && last_wb[rd] >= t + l - 1)
                       || (trk && slot_rd.exists(t + l)));
        e_fire = act && !e_stall;
        e_wbv  = slot_rd.exists(t);
        e_busy = 0;
        for (int r = 0; r < NUM_REGS; r++) if (last_wb[r] >= t) e_busy++;

        check("m_stall", 32'(stall), 32'(e_stall));
        check("m_fire", 32'(issue_fire), 32'(e_fire));
        check("m_wb_valid", 32'(wb_valid), 32'(e_wbv));
        if (e_wbv) check("m_wb_rd", 32'(wb_rd), slot_rd[t]);
        check("m_busy_count", 32'(busy_count), e_busy);

        if (reset) begin
            slot_rd.delete();
            for (int r = 0; r < NUM_REGS; r++) last_wb[r] = -10;
        end else begin
            if (e_wbv) slot_rd.delete(t);
            if (e_fire && trk) begin
                slot_rd[t + l] = rd;
                last_wb[rd]    = t + l;
            end
        end
        t++;
    end

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input bit wr, input int rd, input int lat, input bit fl, input bit rst);
        issue_valid = v;
        issue_rs1   = REG_BITS'(rs1);
        issue_use1  = u1;
        issue_rs2   = REG_BITS'(rs2);
        issue_use2  = u2;
        issue_wr    = wr;
        issue_rd    = REG_BITS'(rd);
        issue_lat   = LAT_W'(lat);
        flush       = fl;
        reset       = rst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic quiet(input int n);
        idle();
        repeat (n) tick();
    endtask

    task automatic issue_wr_only(input int rd, input int lat);
        drive(1, 0, 0, 0, 0, 1, rd, lat, 0, 0);
    endtask

    initial begin
        int  stalls;
        bit  fired;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        quiet(2);

        // Back-to-back ALU: forwarded, no stall, writeback one cycle after fire.
        issue_wr_only(3, LAT_ALU); #1;
        check("alu_fire", 32'(issue_fire), 1);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        check("alu_use_stall", 32'(stall), 0);
        check("alu_wb_valid", 32'(wb_valid), 1);
        check("alu_wb_rd", 32'(wb_rd), 3);
        tick();
        quiet(10);

        // Load-use: one stall cycle, then fire.
        issue_wr_only(4, LAT_LOAD); #1;
        check("load_fire", 32'(issue_fire), 1);
        tick();
        drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0); #1;
        check("load_use_stall", 32'(stall), 1);
        tick();
        #1;
        check("load_use_release", 32'(stall), 0);
        check("load_use_fire", 32'(issue_fire), 1);
        check("load_wb_rd", 32'(wb_rd), 4);
        tick();
        quiet(10);

        // Structural: both would retire in the same writeback cycle.
        issue_wr_only(5, LAT_FPMUL); #1;
        check("struct_first_fire", 32'(issue_fire), 1);
        tick();
        idle(); tick();
        issue_wr_only(6, LAT_FPADD); #1;
        check("struct_stall", 32'(stall), 1);
        tick();
        #1;
        check("struct_retry_fire", 32'(issue_fire), 1);
        tick();
        idle(); #1;
        check("struct_wb_c4", 32'(wb_valid), 0);
        tick();
        check("struct_wb_c5_valid", 32'(wb_valid), 1);
        check("struct_wb_c5_rd", 32'(wb_rd), 5);
        tick();
        check("struct_wb_c6_valid", 32'(wb_valid), 1);
        check("struct_wb_c6_rd", 32'(wb_rd), 6);
        tick();
        quiet(10);

        // WAW: second writer waits until the first counter drops below its latency.
        issue_wr_only(7, LAT_FPMUL);
        tick();
        stalls = 0;
        fired  = 1'b0;
        for (int k = 0; k < 10 && !fired; k++) begin
            issue_wr_only(7, LAT_LOAD); #1;
            if (issue_fire) begin
                fired = 1'b1;
                check("waw_first_wb_valid", 32'(wb_valid), 1);
                check("waw_first_wb_rd", 32'(wb_rd), 7);
            end else begin
                stalls++;
            end
            tick();
        end
        check("waw_fired", 32'(fired), 1);
        check("waw_stall_cycles", stalls, 4);
        idle(); #1;
        check("waw_gap_wb", 32'(wb_valid), 0);
        tick();
        check("waw_second_wb_valid", 32'(wb_valid), 1);
        check("waw_second_wb_rd", 32'(wb_rd), 7);
        quiet(10);

        // Zero register is never tracked.
        issue_wr_only(0, LAT_FPADD); #1;
        check("zero_fire", 32'(issue_fire), 1);
        tick();
        idle(); #1;
        check("zero_busy", 32'(busy_count), 0);
        tick();
        tick();
        check("zero_no_wb", 32'(wb_valid), 0);
        quiet(6);

        // Flush drops a hazarding instruction without touching state.
        issue_wr_only(10, 4);
        tick();
        drive(1, 10, 1, 0, 0, 1, 11, LAT_FPADD, 1, 0); #1;
        check("flush_stall", 32'(stall), 0);
        check("flush_fire", 32'(issue_fire), 0);
        tick();
        drive(1, 10, 1, 0, 0, 1, 11, LAT_FPADD, 0, 0); #1;
        check("flush_then_stall", 32'(stall), 1);
        check("flush_busy", 32'(busy_count), 1);
        tick();
        quiet(10);

        // Reset mid-flight discards the reservation for r9.
        issue_wr_only(9, LAT_FPDIV);
        tick();
        idle(); tick();
        #0;
        check("rst_busy_before", 32'(busy_count), 1);
        tick();
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 1); #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_fire", 32'(issue_fire), 0);
        tick();
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        check("rst_busy_after", 32'(busy_count), 0);
        check("rst_reader_stall", 32'(stall), 0);
        check("rst_reader_fire", 32'(issue_fire), 1);
        tick();
        idle();
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rst_no_wb", 32'(wb_valid), 0);
            tick();
        end
        quiet(4);

        // Random traffic over a few registers to provoke every hazard class.
        for (int n = 0; n < 3000; n++) begin
            drive(int'($urandom_range(0, 9)) < 8,
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 99)) < 10,
                  int'($urandom_range(0, 299)) == 0);
            tick();
        end
        quiet(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
